// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   - Reset / stall polarity constants
//   - Bus widths and the nop word
//   - Fetch FSM state encoding
package if_fetch_ctrl_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch = 2'd0,  // request outstanding at pc
        StHold  = 2'd1,  // word received under stall, parked in hold_inst
        StDrain = 2'd2   // flushed request still waiting for its ack
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues req/ack fetches to instruction memory, stalls the front of the
// pipeline while a fetch is outstanding, and handles the delay-slot branch and the
// exception flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0]               ctrl stall vector, only bit 0 is used here
//   flush, new_pc            exception redirect
//   branch_flag_i, branch_target_address_i   taken branch/jump from ID
//   imem_req_o, imem_addr_o  fetch request, held until imem_ack_i
//   imem_ack_i, imem_rdata_i fetch completion and data
//   pc_o, inst_o             PC / instruction presented to IF/ID
//   stallreq_o               fetch still outstanding
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_address_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   stallreq_o
);

    localparam logic [InstAddrBus-1:0] PcStep = InstAddrBus'(PC_STEP);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   pend_br_q, pend_br_d;
    logic [InstAddrBus-1:0] pend_tgt_q, pend_tgt_d;
    logic [InstBus-1:0]     hold_inst_q, hold_inst_d;
    logic [InstAddrBus-1:0] drain_addr_q, drain_addr_d;

    logic                   stop;
    logic                   advance;
    logic [InstAddrBus-1:0] next_pc;
    logic                   unused_stall;

    assign stop         = (stall[0] == Stop);
    assign unused_stall = ^stall[5:1];

    // A branch captured earlier wins over a new one: the captured one belongs to the
    // delay slot that is just now completing.
    assign next_pc = pend_br_q     ? pend_tgt_q :
                     branch_flag_i ? branch_target_address_i :
                                     pc_q + PcStep;

    // State register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            pend_br_q    <= 1'b0;
            pend_tgt_q   <= ZeroWord;
            hold_inst_q  <= ZeroWord;
            drain_addr_q <= ZeroWord;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_br_q    <= pend_br_d;
            pend_tgt_q   <= pend_tgt_d;
            hold_inst_q  <= hold_inst_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_br_d    = pend_br_q;
        pend_tgt_d   = pend_tgt_q;
        hold_inst_d  = hold_inst_q;
        drain_addr_d = drain_addr_q;
        advance      = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (imem_ack_i) begin
                    if (!stop) begin
                        advance = 1'b1;
                    end else begin
                        hold_inst_d = imem_rdata_i;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (!stop) begin
                    advance = 1'b1;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (imem_ack_i) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        // A branch seen while the delay slot has not completed is remembered, so the
        // slot finishes first and the target is fetched afterwards.
        if (advance) begin
            pc_d      = next_pc;
            pend_br_d = 1'b0;
        end else if (branch_flag_i) begin
            pend_br_d  = 1'b1;
            pend_tgt_d = branch_target_address_i;
        end

        // Flush overrides everything, including stall; an unacked request cannot be
        // aborted, so its address is kept for the drain.
        if (flush) begin
            pc_d        = new_pc;
            pend_br_d   = 1'b0;
            hold_inst_d = ZeroWord;
            unique case (state_q)
                StFetch: begin
                    state_d      = imem_ack_i ? StFetch : StDrain;
                    drain_addr_d = pc_q;
                end
                StHold:  state_d = StFetch;
                StDrain: state_d = imem_ack_i ? StFetch : StDrain;
                default: state_d = StFetch;
            endcase
        end
    end

    // Outputs; everything is forced quiet while reset is held so an in-flight request
    // drops immediately.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = ZeroWord;
        pc_o        = ZeroWord;
        inst_o      = ZeroWord;
        stallreq_o  = 1'b0;
        if (rst != RstEnable) begin
            unique case (state_q)
                StFetch: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc_q;
                    pc_o        = pc_q;
                    stallreq_o  = !imem_ack_i;
                    if (imem_ack_i && !stop) begin
                        inst_o = imem_rdata_i;
                    end
                end
                StHold: begin
                    pc_o   = pc_q;
                    inst_o = hold_inst_q;
                end
                StDrain: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = drain_addr_q;
                    pc_o        = pc_q;
                    stallreq_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stallreq_o;

    int nvec;
    int nerr;

    if_fetch_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_ack_i              (imem_ack_i),
        .imem_rdata_i            (imem_rdata_i),
        .pc_o                    (pc_o),
        .inst_o                  (inst_o),
        .stallreq_o              (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
            #1;
            nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", imem_req_o); end
            nvec++; if (stallreq_o !== 1'b0) begin nerr++; $display("FAIL rst_stallreq got %b want 0", stallreq_o); end
            nvec++; if (pc_o !== 32'h0) begin nerr++; $display("FAIL rst_pc got %h want 0", pc_o); end
            nvec++; if (inst_o !== 32'h0) begin nerr++; $display("FAIL rst_inst got %h want 0", inst_o); end
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'hA000_0000 + i;
            #1;
            nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL seq_req[%0d] got %b want 1", i, imem_req_o); end
            nvec++; if (imem_addr_o !== 32'(4 * i)) begin nerr++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr_o, 32'(4 * i)); end
            nvec++; if (stallreq_o !== 1'b0) begin nerr++; $display("FAIL seq_stallreq[%0d] got %b want 0", i, stallreq_o); end
            nvec++; if (inst_o !== 32'hA000_0000 + i) begin nerr++; $display("FAIL seq_inst[%0d] got %h want %h", i, inst_o, 32'hA000_0000 + i); end
        end
    endtask

    // pc = 0x10 on entry; leaves pc = 0x24
    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack_i = 1'b0; imem_rdata_i = 32'h5555_5555;
            #1;
            nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin nerr++; $display("FAIL wait_req[%0d] got %b/%h want 1/00000010", i, imem_req_o, imem_addr_o); end
            nvec++; if (stallreq_o !== 1'b1) begin nerr++; $display("FAIL wait_stallreq[%0d] got %b want 1", i, stallreq_o); end
            nvec++; if (inst_o !== 32'h0) begin nerr++; $display("FAIL wait_inst[%0d] got %h want 0", i, inst_o); end
        end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h1111_0010;
        #1;
        nvec++; if (inst_o !== 32'h1111_0010) begin nerr++; $display("FAIL wait_ack_inst got %h want 11110010", inst_o); end
        nvec++; if (stallreq_o !== 1'b0) begin nerr++; $display("FAIL wait_ack_stallreq got %b want 0", stallreq_o); end
        nvec++; if (pc_o !== 32'h10) begin nerr++; $display("FAIL wait_ack_pc got %h want 00000010", pc_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack_i = 1'b1; imem_rdata_i = 32'h2222_0000 + i;
            #1;
            nvec++; if (imem_addr_o !== 32'h14 + 32'(4 * i)) begin nerr++; $display("FAIL wait_next_addr[%0d] got %h want %h", i, imem_addr_o, 32'h14 + 32'(4 * i)); end
        end
    endtask

    // pc = 0x24 on entry; leaves pc = 0x104
    task automatic test_delay_slot_branch();
        @(negedge clk);
        imem_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        #1;
        nvec++; if (imem_addr_o !== 32'h24 || stallreq_o !== 1'b1) begin nerr++; $display("FAIL br_slot0 got %h/%b want 00000024/1", imem_addr_o, stallreq_o); end
        @(negedge clk);
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        #1;
        nvec++; if (imem_addr_o !== 32'h24) begin nerr++; $display("FAIL br_slot1 got %h want 00000024", imem_addr_o); end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hD5D5_0024;
        #1;
        nvec++; if (imem_addr_o !== 32'h24 || inst_o !== 32'hD5D5_0024) begin nerr++; $display("FAIL br_slot_ack got %h/%h want 00000024/d5d50024", imem_addr_o, inst_o); end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h7777_0100;
        #1;
        nvec++; if (imem_addr_o !== 32'h100) begin nerr++; $display("FAIL br_target got %h want 00000100", imem_addr_o); end
    endtask

    // pc = 0x104 on entry; leaves pc = 0x10C
    task automatic test_hold();
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFE_0104; stall = 6'b000011;
        #1;
        nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h104) begin nerr++; $display("FAIL hold_ack got %b/%h want 1/00000104", imem_req_o, imem_addr_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack_i = 1'b0; imem_rdata_i = 32'h0; stall = (i < 2) ? 6'b000011 : 6'b000000;
            #1;
            nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL hold_req[%0d] got %b want 0", i, imem_req_o); end
            nvec++; if (inst_o !== 32'hCAFE_0104) begin nerr++; $display("FAIL hold_inst[%0d] got %h want cafe0104", i, inst_o); end
            nvec++; if (stallreq_o !== 1'b0 || pc_o !== 32'h104) begin nerr++; $display("FAIL hold_pc[%0d] got %b/%h want 0/00000104", i, stallreq_o, pc_o); end
        end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0108;
        #1;
        nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h108) begin nerr++; $display("FAIL hold_release got %b/%h want 1/00000108", imem_req_o, imem_addr_o); end
    endtask

    // pc = 0x10C on entry; leaves pc = 0x24
    task automatic test_flush_drain();
        @(negedge clk);
        imem_ack_i = 1'b1; branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
        #1;
        nvec++; if (imem_addr_o !== 32'h10C) begin nerr++; $display("FAIL fl_pre got %h want 0000010c", imem_addr_o); end
        @(negedge clk);
        branch_flag_i = 1'b0; imem_ack_i = 1'b0; flush = 1'b1; new_pc = 32'h20;
        #1;
        nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin nerr++; $display("FAIL fl_req got %b/%h want 1/00000040", imem_req_o, imem_addr_o); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin nerr++; $display("FAIL fl_drain_req got %b/%h want 1/00000040", imem_req_o, imem_addr_o); end
        nvec++; if (stallreq_o !== 1'b1 || inst_o !== 32'h0) begin nerr++; $display("FAIL fl_drain_out got %b/%h want 1/00000000", stallreq_o, inst_o); end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_0040;
        #1;
        nvec++; if (imem_addr_o !== 32'h40 || inst_o !== 32'h0) begin nerr++; $display("FAIL fl_drain_ack got %h/%h want 00000040/00000000", imem_addr_o, inst_o); end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h2020_2020;
        #1;
        nvec++; if (imem_addr_o !== 32'h20 || inst_o !== 32'h2020_2020) begin nerr++; $display("FAIL fl_new got %h/%h want 00000020/20202020", imem_addr_o, inst_o); end
    endtask

    // pc = 0x24 on entry
    task automatic test_reset_mid_request();
        @(negedge clk);
        imem_ack_i = 1'b0;
        #1;
        nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h24) begin nerr++; $display("FAIL mr_req got %b/%h want 1/00000024", imem_req_o, imem_addr_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL mr_drop got %b want 0", imem_req_o); end
        @(negedge clk);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_0024;
        #1;
        nvec++; if (imem_req_o !== 1'b0 || inst_o !== 32'h0) begin nerr++; $display("FAIL mr_late_ack got %b/%h want 0/00000000", imem_req_o, inst_o); end
        @(negedge clk);
        rst = 1'b0; imem_ack_i = 1'b0;
        #1;
        nvec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin nerr++; $display("FAIL mr_restart got %b/%h want 1/00000000", imem_req_o, imem_addr_o); end
        nvec++; if (stallreq_o !== 1'b1 || inst_o !== 32'h0) begin nerr++; $display("FAIL mr_restart_out got %b/%h want 1/00000000", stallreq_o, inst_o); end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst = 1'b1; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_delay_slot_branch();
        test_hold();
        test_flush_drain();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
